// File: rtl/fp16_mac_pkg.sv
// +----------------------------------------------------------------------------+
// | fp16_mac_pkg                                                               |
// | Shared state encoding and fp16 constants for the fp16 MAC sequencer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp16_mac_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fp16_mac_sequencer.sv
// +----------------------------------------------------------------------------+
// | fp16_mac_sequencer                                                         |
// | Streams fp16 operand pairs through an external FMA and accumulates one     |
// | dot-product per vector. Optional macro FP16_MAC_BIAS_EN adds a bias port   |
// | that seeds the accumulator on start.                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp16_mac_sequencer
  import fp16_mac_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef FP16_MAC_BIAS_EN
  input  logic [FP16_W-1:0] bias,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_a,
  input  logic [FP16_W-1:0] in_b,
  input  logic              in_last,
  output logic [FP16_W-1:0] fma_op1,
  output logic [FP16_W-1:0] fma_op2,
  output logic [FP16_W-1:0] fma_ops,
  input  logic [FP16_W-1:0] fma_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP16_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic [FP16_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FP16_W-1:0]   w_acc_init;
  logic                w_accum;
  logic                w_in_fire;

`ifdef FP16_MAC_BIAS_EN
  assign w_acc_init = bias;
`else
  assign w_acc_init = FP16_ZERO;
`endif

  assign w_accum   = (state_q == ACCUM);
  assign w_in_fire = w_accum && in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = w_acc_init;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (w_in_fire) begin
          // Accumulator keeps chaining even once the count has saturated.
          acc_d = fma_result;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= FP16_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = w_accum;
  assign fma_op1   = w_accum ? in_a : FP16_ZERO;
  assign fma_op2   = w_accum ? in_b : FP16_ZERO;
  assign fma_ops   = acc_q;
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fp16_mac_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_fp16_mac_sequencer                                                      |
// | Scoreboard bench for fp16_mac_sequencer with a behavioral FMA model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fp16_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bias = 16'h0000;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, busy;
  logic [15:0] fma_op1, fma_op2, fma_ops, fma_result, out_data;
  logic [7:0]  out_count;

  logic        in_ready2, out_valid2, busy2;
  logic [15:0] fma2_op1, fma2_op2, fma2_ops, fma2_result, out_data2;
  logic [1:0]  out_count2;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] q_ops[$];
  logic [15:0] q_data[$];
  int          q_cnt[$];
  int          q_cnt2[$];

  always #5 clk = ~clk;

  // Operands always carry a hidden 1, so a zero encoding is +2^-15.
  function automatic real fp_val(input logic [15:0] h);
    real m;
    int  e;
    m = 1.0 + real'(int'(h[9:0])) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] fp_enc(input real x);
    logic s;
    real  y, r, fl, fr;
    int   e, mant;
    s = (x < 0.0);
    y = s ? -x : x;
    if (y == 0.0) return 16'h0000;
    e = 15;
    while (y >= 2.0 && e < 30) begin y = y / 2.0; e++; end
    while (y < 1.0 && e > 0) begin y = y * 2.0; e--; end
    r    = (y - 1.0) * 1024.0;
    fl   = $floor(r);
    fr   = r - fl;
    mant = int'(fl);
    if (fr > 0.5 || (fr == 0.5 && mant[0])) mant++;
    if (mant == 1024) begin mant = 0; e++; end
    return {s, e[4:0], mant[9:0]};
  endfunction

  function automatic logic [15:0] fma_model(input logic [15:0] a, b, c);
    return fp_enc(fp_val(a) * fp_val(b) + fp_val(c));
  endfunction

  always_comb fma_result  = fma_model(fma_op1, fma_op2, fma_ops);
  always_comb fma2_result = fma_model(fma2_op1, fma2_op2, fma2_ops);

  fp16_mac_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef FP16_MAC_BIAS_EN
    .bias(bias),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .fma_op1(fma_op1), .fma_op2(fma_op2), .fma_ops(fma_ops),
    .fma_result(fma_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  // Narrow-counter copy runs in lockstep to exercise saturation.
  fp16_mac_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
`ifdef FP16_MAC_BIAS_EN
    .bias(bias),
`endif
    .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .fma_op1(fma2_op1), .fma_op2(fma2_op2), .fma_ops(fma2_ops),
    .fma_result(fma2_result), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_count(out_count2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares FMA operands on each input handshake and results on each output handshake.
  logic        hold_prev = 1'b0;
  logic [15:0] prev_data;
  logic [7:0]  prev_cnt;
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      chk("fma_op1", {16'h0, fma_op1}, {16'h0, in_a});
      chk("fma_op2", {16'h0, fma_op2}, {16'h0, in_b});
      if (q_ops.size() == 0) chk("ops_queue_empty", 32'd1, 32'd0);
      else chk("fma_ops", {16'h0, fma_ops}, {16'h0, q_ops.pop_front()});
    end
    if (!rst && out_valid && !out_ready) begin
      if (hold_prev) begin
        chk("hold_data", {16'h0, out_data}, {16'h0, prev_data});
        chk("hold_count", {24'h0, out_count}, {24'h0, prev_cnt});
      end
      prev_data = out_data;
      prev_cnt  = out_count;
      hold_prev = 1'b1;
    end else begin
      hold_prev = 1'b0;
    end
    if (!rst && out_valid && out_ready) begin
      if (q_data.size() == 0) chk("res_queue_empty", 32'd1, 32'd0);
      else begin
        chk("out_data", {16'h0, out_data}, {16'h0, q_data[0]});
        chk("out_data_w2", {16'h0, out_data2}, {16'h0, q_data.pop_front()});
        chk("out_count", {24'h0, out_count}, q_cnt.pop_front());
        chk("out_count_w2", {30'h0, out_count2}, q_cnt2.pop_front());
        chk("out_valid_w2", {31'h0, out_valid2}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b);
    bias  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("in_ready_after_start", {31'h0, in_ready}, 32'd1);
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b,
                           input logic last, input logic [15:0] exp_ops);
    int n = 0;
    q_ops.push_back(exp_ops);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("in_ready_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap(input logic [15:0] exp_ops);
    chk("gap_acc_hold", {16'h0, fma_ops}, {16'h0, exp_ops});
    tick();
  endtask

  task automatic push_res(input logic [15:0] d, input int c, input int c2);
    q_data.push_back(d);
    q_cnt.push_back(c);
    q_cnt2.push_back(c2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {16'h0, out_data}, 32'h0);
    chk({tag, "_out_count"}, {24'h0, out_count}, 32'h0);
    chk({tag, "_fma_ops"}, {16'h0, fma_ops}, 32'h0);
    chk({tag, "_fma_op1_op2"}, {fma_op1, fma_op2}, 32'h0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single pair: 1.0*2.0 + 2^-15 rounds to 2.0.
    do_start(16'h0000);
    push_res(16'h4000, 1, 1);
    send_pair(16'h3C00, 16'h4000, 1'b1, 16'h0000);
    chk("single_out_valid_latency", {31'h0, out_valid}, 32'd1);
    wait_idle();
    chk("single_fma_idle_zero", {fma_op1, fma_op2}, 32'h0);

    // Back-to-back: acc 1, 2, 8, 7.
    do_start(16'h0000);
    push_res(16'h4700, 4, 3);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h0000);
    send_pair(16'h4000, 16'h3800, 1'b0, 16'h3C00);
    send_pair(16'h4200, 16'h4000, 1'b0, 16'h4000);
    send_pair(16'h3C00, 16'hBC00, 1'b1, 16'h4800);
    chk("b2b_out_valid_latency", {31'h0, out_valid}, 32'd1);
    wait_idle();

    // Same pairs with gaps.
    do_start(16'h0000);
    push_res(16'h4700, 4, 3);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h0000);
    gap(16'h3C00);
    send_pair(16'h4000, 16'h3800, 1'b0, 16'h3C00);
    gap(16'h4000);
    send_pair(16'h4200, 16'h4000, 1'b0, 16'h4000);
    gap(16'h4800);
    send_pair(16'h3C00, 16'hBC00, 1'b1, 16'h4800);
    wait_idle();

    // Backpressure with start pulsing in DONE.
    do_start(16'h0000);
    push_res(16'h4400, 1, 1);
    out_ready = 1'b0;
    send_pair(16'h4000, 16'h4000, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      start = (i != 1);
      tick();
      chk("bp_busy", {31'h0, busy}, 32'd1);
      chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_idle_after_handshake", {31'h0, busy}, 32'd0);
    chk("bp_start_at_handshake_ignored", {31'h0, in_ready}, 32'd0);

    // Six pairs: wide count 6, narrow count saturates at 3; acc reaches 6.0.
    do_start(16'h0000);
    push_res(16'h4600, 6, 3);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h0000);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h3C00);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h4000);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h4200);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h4400);
    send_pair(16'h3C00, 16'h3C00, 1'b1, 16'h4500);
    wait_idle();

    // Reset mid-vector discards the partial sum.
    do_start(16'h0000);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h0000);
    send_pair(16'h3C00, 16'h3C00, 1'b0, 16'h3C00);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    tick();

`ifdef FP16_MAC_BIAS_EN
    do_start(16'h3C00);
    push_res(16'h4000, 1, 1);
    send_pair(16'h3C00, 16'h3C00, 1'b1, 16'h3C00);
`else
    do_start(16'h3C00);
    push_res(16'h3C00, 1, 1);
    send_pair(16'h3C00, 16'h3C00, 1'b1, 16'h0000);
`endif
    wait_idle();
    tick();

    chk("ops_queue_drained", q_ops.size(), 32'd0);
    chk("res_queue_drained", q_data.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
